// File: rtl/player_pkg.sv
// Shared types and default screen geometry for the player motion controller.
package player_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    APEX = 2'd2,
    FALL = 2'd3
  } jump_state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int DEF_X_MAX    = 600;
  localparam int DEF_X_START  = 320;
  localparam int DEF_GROUND_Y = 400;
endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one active-low button; output is active-high pressed.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);
  logic [1:0] sync;

  // Reset to the released level so no phantom press follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], btn_n};
  end

  assign pressed = ~sync[1];
endmodule

// File: rtl/player_motion_ctrl.sv
// Player X/Y motion, jump FSM and sticky obstacle hit for the runner game.
// Build option PLAYER_WRAP_EN: horizontal wrap-around instead of clamping.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int X_START   = DEF_X_START,
  parameter int STEP      = 5,
  parameter int GROUND_Y  = DEF_GROUND_Y,
  parameter int JUMP_H    = 100,
  parameter int JUMP_STEP = 10,
  parameter int HANG      = 4,
  parameter int P_W       = 32,
  parameter int P_H       = 32,
  parameter int OBS_W     = 16,
  parameter int OBS_H     = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           btn_right_n,
  input  logic           btn_left_n,
  input  logic           btn_jump_n,
  input  logic           obs_valid,
  input  logic [X_W-1:0] obs_x,
  input  logic [Y_W-1:0] obs_y,
  input  logic           hit_clr,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     state,
  output logic           hit
);
  localparam int NBTN = 3;
  localparam int HW   = (HANG < 1) ? 1 : $clog2(HANG + 1);

`ifdef PLAYER_WRAP_EN
  localparam int X_OVER  = X_MIN;
  localparam int X_UNDER = X_MAX;
`else
  localparam int X_OVER  = X_MAX;
  localparam int X_UNDER = X_MIN;
`endif

  localparam logic [X_W:0]   STEP_X  = (X_W+1)'(STEP);
  localparam logic [X_W:0]   XMAX_X  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]   XMIN_X  = (X_W+1)'(X_MIN);
  localparam logic [Y_W-1:0] GND_Y   = Y_W'(GROUND_Y);
  localparam logic [Y_W-1:0] APEX_Y  = Y_W'(GROUND_Y - JUMP_H);
  localparam logic [Y_W-1:0] JSTEP_Y = Y_W'(JUMP_STEP);

  // Buttons: bit 0 right, bit 1 left, bit 2 jump.
  logic [NBTN-1:0] btn_n_vec, pressed;
  assign btn_n_vec = {btn_jump_n, btn_left_n, btn_right_n};

  for (genvar i = 0; i < NBTN; i++) begin : g_sync
    btn_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n_vec[i]),
      .pressed(pressed[i])
    );
  end

  logic right, left, jump;
  assign right = pressed[0];
  assign left  = pressed[1];
  assign jump  = pressed[2];

  logic adv;
  assign adv = tick & ~hit;

  // Horizontal: one extra bit so neither bound can wrap before comparison.
  logic [X_W:0]        x_ext, x_sum;
  logic signed [X_W:0] x_dif;
  logic [X_W-1:0]      x_nxt;

  always_comb begin
    x_ext = {1'b0, pos_x};
    x_sum = x_ext + STEP_X;
    x_dif = $signed(x_ext) - $signed(STEP_X);
    x_nxt = pos_x;
    if (right && !left) begin
      if (x_sum > XMAX_X) x_nxt = X_W'(X_OVER);
      else                x_nxt = x_sum[X_W-1:0];
    end else if (left && !right) begin
      if (x_dif < $signed(XMIN_X)) x_nxt = X_W'(X_UNDER);
      else                         x_nxt = x_dif[X_W-1:0];
    end
  end

  // Jump FSM
  jump_state_t    st, st_nxt;
  logic [HW-1:0]  hang, hang_nxt;
  logic [Y_W-1:0] y_nxt, y_dec;
  logic [Y_W:0]   y_inc;
  logic           armed, accept;

  assign y_dec  = pos_y - JSTEP_Y;
  assign y_inc  = {1'b0, pos_y} + {1'b0, JSTEP_Y};
  assign accept = adv && (st == IDLE) && jump && armed;

  always_comb begin
    st_nxt   = st;
    y_nxt    = pos_y;
    hang_nxt = hang;
    if (adv) begin
      case (st)
        IDLE: begin
          y_nxt = GND_Y;
          if (jump && armed) st_nxt = RISE;
        end
        RISE: begin
          y_nxt = y_dec;
          if (y_dec == APEX_Y) begin
            st_nxt   = APEX;
            hang_nxt = HW'(HANG);
          end
        end
        // Count reaching zero on this tick ends the hang; HANG=0 still gives one tick.
        APEX: begin
          if (hang <= HW'(1)) begin
            hang_nxt = '0;
            st_nxt   = FALL;
          end else begin
            hang_nxt = hang - HW'(1);
          end
        end
        FALL: begin
          if (y_inc >= {1'b0, GND_Y}) begin
            y_nxt  = GND_Y;
            st_nxt = IDLE;
          end else begin
            y_nxt = y_inc[Y_W-1:0];
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Collision on registered positions, two extra bits for the far edges.
  logic [X_W+1:0] px_lo, px_hi, ox_lo, ox_hi;
  logic [Y_W+1:0] py_lo, py_hi, oy_lo, oy_hi;
  logic           overlap;

  always_comb begin
    px_lo   = {2'b00, pos_x};
    px_hi   = px_lo + (X_W+2)'(P_W);
    ox_lo   = {2'b00, obs_x};
    ox_hi   = ox_lo + (X_W+2)'(OBS_W);
    py_lo   = {2'b00, pos_y};
    py_hi   = py_lo + (Y_W+2)'(P_H);
    oy_lo   = {2'b00, obs_y};
    oy_hi   = oy_lo + (Y_W+2)'(OBS_H);
    overlap = obs_valid && (px_lo < ox_hi) && (ox_lo < px_hi) &&
              (py_lo < oy_hi) && (oy_lo < py_hi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= X_W'(X_START);
      pos_y <= GND_Y;
      st    <= IDLE;
      hang  <= '0;
      armed <= 1'b1;
      hit   <= 1'b0;
    end else begin
      if (adv) pos_x <= x_nxt;
      pos_y <= y_nxt;
      st    <= st_nxt;
      hang  <= hang_nxt;
      // Re-arm only once the held jump has been let go.
      if (accept)     armed <= 1'b0;
      else if (!jump) armed <= 1'b1;
      hit <= overlap | (hit & ~hit_clr);
    end
  end

  assign state = st;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed, table-driven bench for player_motion_ctrl plus hand-written corner sequences.
module tb_player_motion_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_right_n = 1'b1, btn_left_n = 1'b1, btn_jump_n = 1'b1;
  logic       obs_valid = 1'b0, obs_off = 1'b0, hit_clr = 1'b0;
  logic [9:0] obs_x = '0, pos_x, pos_x2;
  logic [9:0] obs_y = '0, pos_y, pos_y2;
  logic [1:0] state, state2;
  logic       hit, hit2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_right_n(btn_right_n), .btn_left_n(btn_left_n), .btn_jump_n(btn_jump_n),
    .obs_valid(obs_valid), .obs_x(obs_x), .obs_y(obs_y), .hit_clr(hit_clr),
    .pos_x(pos_x), .pos_y(pos_y), .state(state), .hit(hit)
  );

  // Second instance starts near the right edge for the partial-step boundary cases.
  player_motion_ctrl #(.X_START(598)) dut2 (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_right_n(btn_right_n), .btn_left_n(btn_left_n), .btn_jump_n(btn_jump_n),
    .obs_valid(obs_off), .obs_x(obs_x), .obs_y(obs_y), .hit_clr(hit_clr),
    .pos_x(pos_x2), .pos_y(pos_y2), .state(state2), .hit(hit2)
  );

  typedef struct {
    logic r, l, j;
    int   n;
    int   ex, ey, es;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic r, input logic l, input logic j);
    @(negedge clk);
    btn_right_n = ~r;
    btn_left_n  = ~l;
    btn_jump_n  = ~j;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 10, 370, 400, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0,  3, 370, 400, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0,  2, 360, 400, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0,  3, 360, 400, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1,  1, 360, 400, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1,  5, 360, 350, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1,  5, 360, 300, 2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1,  3, 360, 300, 2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1,  1, 360, 300, 3};
    tbl[9]  = '{1'b0, 1'b0, 1'b1,  9, 360, 390, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b1,  1, 360, 400, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1,  3, 360, 400, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0,  1, 360, 400, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b1,  1, 360, 400, 1};
    tbl[14] = '{1'b1, 1'b0, 1'b0,  2, 370, 380, 1};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x", pos_x, 320);
    chk("rst_y", pos_y, 400);
    chk("rst_state", state, 0);
    chk("rst_hit", hit, 0);

    // Movement and jump vectors
    for (int i = 0; i < 15; i++) begin
      set_btn(tbl[i].r, tbl[i].l, tbl[i].j);
      do_tick(tbl[i].n);
      chk($sformatf("v%0d_x", i), pos_x, tbl[i].ex);
      chk($sformatf("v%0d_y", i), pos_y, tbl[i].ey);
      chk($sformatf("v%0d_state", i), state, tbl[i].es);
    end

    // Asynchronous reset while rising, away from any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", pos_x, 320);
    chk("arst_y", pos_y, 400);
    chk("arst_state", state, 0);
    chk("arst_hit", hit, 0);
    btn_right_n = 1'b1;
    btn_left_n  = 1'b1;
    btn_jump_n  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Overlap, freeze, sticky hit and clear
    obs_x = 10'd340;
    obs_y = 10'd410;
    obs_valid = 1'b1;
    #1 chk("hit_pre", hit, 0);
    @(negedge clk);
    chk("hit_rise", hit, 1);
    set_btn(1'b1, 1'b0, 1'b1);
    do_tick(3);
    chk("frz_x", pos_x, 320);
    chk("frz_y", pos_y, 400);
    chk("frz_state", state, 0);
    set_btn(1'b0, 1'b0, 1'b0);
    @(negedge clk) hit_clr = 1'b1;
    @(negedge clk) hit_clr = 1'b0;
    chk("clr_ovl_hit", hit, 1);
    obs_valid = 1'b0;
    @(negedge clk);
    chk("sticky_hit", hit, 1);
    hit_clr = 1'b1;
    @(negedge clk) hit_clr = 1'b0;
    chk("clr_hit", hit, 0);
    set_btn(1'b1, 1'b0, 1'b0);
    do_tick(1);
    chk("resume_x", pos_x, 325);
    chk("resume_state", state, 0);

    // Touching edges do not overlap; one step right does
    set_btn(1'b0, 1'b0, 1'b0);
    do_reset();
    obs_x = 10'd352;
    obs_y = 10'd400;
    obs_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("touch_hit", hit, 0);
    set_btn(1'b1, 1'b0, 1'b0);
    do_tick(1);
    chk("edge_x", pos_x, 325);
    chk("edge_hit_lat", hit, 0);
    @(negedge clk);
    chk("edge_hit", hit, 1);
    do_tick(2);
    chk("edge_frz_x", pos_x, 325);

    // Horizontal bounds
    obs_valid = 1'b0;
    set_btn(1'b0, 1'b0, 1'b0);
    hit_clr = 1'b1;
    do_reset();
    hit_clr = 1'b0;
    set_btn(1'b0, 1'b1, 1'b0);
    do_tick(119);
    chk("lo_approach_x2", pos_x2, 3);
`ifdef PLAYER_WRAP_EN
    chk("lo_long_x", pos_x, 330);
`else
    chk("lo_long_x", pos_x, 0);
`endif
    do_tick(1);
`ifdef PLAYER_WRAP_EN
    chk("lo_edge_x2", pos_x2, 600);
    chk("lo_edge_x", pos_x, 325);
`else
    chk("lo_edge_x2", pos_x2, 0);
    chk("lo_edge_x", pos_x, 0);
`endif
    set_btn(1'b0, 1'b0, 1'b0);
    do_reset();
    set_btn(1'b1, 1'b0, 1'b0);
    do_tick(1);
`ifdef PLAYER_WRAP_EN
    chk("hi_edge_x2", pos_x2, 0);
`else
    chk("hi_edge_x2", pos_x2, 600);
`endif
    chk("hi_edge_x", pos_x, 325);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
